// File: rtl/uart_pkg.sv
// Shared UART constants: state encoding, default bit timing, frame sizes.
// Used by uart_tx_serial, the frame packer and uart_rx.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 434;

   localparam int START_BITS = 1;
   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS_8N1 = START_BITS + DATA_BITS + 1;
   localparam int FRAME_BITS_8N2 = START_BITS + DATA_BITS + 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP
   } state_t;

   function automatic int frame_bits(input int stop_bits);
      return START_BITS + DATA_BITS + stop_bits;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses o_bit_end on the last.
// Ports: i_clk, i_rst (sync, high), i_clr (restart at 0), o_bit_end.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   output logic o_bit_end
);

   localparam int W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr)
         r_cnt <= '0;
      else if (r_cnt == LAST)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_bit_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_serial.sv
// UART 8N1/8N2 transmitter with a one-byte holding register.
// Ports: i_clk, i_rst, i_tx_dv, i_tx_byte[7:0] -> o_tx_ready,
//        o_tx_serial, o_tx_active, o_tx_done.
module uart_tx_serial
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int STOP_BITS    = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tx_dv,
   input  logic [7:0] i_tx_byte,
   output logic       o_tx_ready,
   output logic       o_tx_serial,
   output logic       o_tx_active,
   output logic       o_tx_done
);

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

   state_t     r_state, w_next;
   logic [2:0] r_bit_idx, w_bit_nxt;
   logic [7:0] r_hold, r_shift;
   logic       r_hold_valid;
   logic       r_serial, r_active, r_last, r_done;
   logic       w_bit_end, w_load, w_stop_end;
   logic       w_line, w_clr, w_accept;

   assign w_accept = i_tx_dv && !r_hold_valid;

   // Counter restarts at 0 on every state entry and stays parked in IDLE.
   assign w_clr = (r_state == IDLE) || (w_next != r_state);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (w_clr),
      .o_bit_end (w_bit_end)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_bit_idx <= '0;
      end else begin
         r_state   <= w_next;
         r_bit_idx <= w_bit_nxt;
      end
   end

   // r_bit_idx indexes data bits in DATA and stop bits in STOP.
   always_comb begin
      w_next     = r_state;
      w_bit_nxt  = r_bit_idx;
      w_load     = 1'b0;
      w_stop_end = 1'b0;
      w_line     = 1'b1;
      unique case (r_state)
         IDLE: begin
            if (r_hold_valid) begin
               w_next    = START;
               w_load    = 1'b1;
               w_bit_nxt = '0;
            end
         end
         START: begin
            w_line = 1'b0;
            if (w_bit_end) begin
               w_next    = DATA;
               w_bit_nxt = '0;
            end
         end
         DATA: begin
            w_line = r_shift[r_bit_idx];
            if (w_bit_end) begin
               if (r_bit_idx == LAST_DATA) begin
                  w_next    = STOP;
                  w_bit_nxt = '0;
               end else begin
                  w_bit_nxt = r_bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (w_bit_end) begin
               if (r_bit_idx == LAST_STOP) begin
                  w_stop_end = 1'b1;
                  w_bit_nxt  = '0;
                  if (r_hold_valid) begin
                     w_next = START;
                     w_load = 1'b1;
                  end else begin
                     w_next = IDLE;
                  end
               end else begin
                  w_bit_nxt = r_bit_idx + 3'd1;
               end
            end
         end
      endcase
   end

   // Outputs are a registered image of the FSM, one cycle behind it;
   // the done pulse takes a second stage so it lands on the line's
   // end of the last stop bit, together with the active drop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hold_valid <= 1'b0;
         r_serial     <= 1'b1;
         r_active     <= 1'b0;
         r_last       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         if (w_load)
            r_hold_valid <= 1'b0;
         else if (w_accept)
            r_hold_valid <= 1'b1;
         r_serial <= w_line;
         r_active <= (r_state != IDLE);
         r_last   <= w_stop_end;
         r_done   <= r_last;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_accept)
         r_hold <= i_tx_byte;
      if (w_load)
         r_shift <= r_hold;
   end

   assign o_tx_ready  = !r_hold_valid;
   assign o_tx_serial = r_serial;
   assign o_tx_active = r_active;
   assign o_tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx_serial.sv
// Directed bench for uart_tx_serial: line monitor decodes frames against
// a scoreboard of accepted bytes; second instance covers STOP_BITS=2.
module tb_uart_tx_serial;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dv_a = 1'b0;
   logic [7:0] byte_a = 8'h00;
   logic       dv_b = 1'b0;
   logic [7:0] byte_b = 8'h00;
   logic       ready_a, serial_a, active_a, done_a;
   logic       ready_b, serial_b, active_b, done_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] sb[$];
   int         fall_q[$];
   int         done_q[$];
   int         done_cnt = 0;
   int         frame_cnt = 0;

   bit         busy = 1'b0;
   int         mcnt = 0;
   logic [7:0] mdata = 8'h00;
   logic       mstart = 1'b1;
   logic       mstop = 1'b0;

   uart_tx_serial #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tx_dv     (dv_a),
      .i_tx_byte   (byte_a),
      .o_tx_ready  (ready_a),
      .o_tx_serial (serial_a),
      .o_tx_active (active_a),
      .o_tx_done   (done_a)
   );

   uart_tx_serial #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_tx_dv     (dv_b),
      .i_tx_byte   (byte_b),
      .o_tx_ready  (ready_b),
      .o_tx_serial (serial_b),
      .o_tx_active (active_b),
      .o_tx_done   (done_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_a(input logic [7:0] b, input bit push);
      dv_a   = 1'b1;
      byte_a = b;
      step(1);
      dv_a   = 1'b0;
      if (push) sb.push_back(b);
   endtask

   // Frame decoder on dut_a's line, sampling mid-bit at 4 clocks/bit.
   always @(negedge clk) begin
      if (rst) begin
         busy = 1'b0;
      end else begin
         if (done_a) begin
            done_cnt++;
            done_q.push_back(cyc);
         end
         if (!busy) begin
            if (serial_a === 1'b0) begin
               busy = 1'b1;
               mcnt = 0;
               fall_q.push_back(cyc);
            end
         end else begin
            mcnt++;
         end
         if (busy) begin
            if (mcnt == 2) mstart = serial_a;
            if (mcnt >= 6 && mcnt <= 34 && (mcnt % 4) == 2)
               mdata[(mcnt - 6) / 4] = serial_a;
            if (mcnt == 38) mstop = serial_a;
            if (mcnt == 39) begin
               busy = 1'b0;
               frame_cnt++;
               chk("frame_start", 32'(mstart), 32'd0);
               chk("frame_stop", 32'(mstop), 32'd1);
               if (sb.size() == 0) begin
                  chk("frame_unexpected", 32'(mdata), 32'hFFFF_FFFF);
               end else begin
                  chk("frame_byte", 32'(mdata), 32'(sb.pop_front()));
               end
            end
         end
      end
   end

   initial begin
      int a;
      int n_done, n_frame, n_fall;
      int bad, done_off, done_hits;

      // Reset held 3 cycles
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("rst_serial", 32'(serial_a), 32'd1);
         chk("rst_ready", 32'(ready_a), 32'd1);
         chk("rst_active", 32'(active_a), 32'd0);
         chk("rst_done", 32'(done_a), 32'd0);
      end
      rst = 1'b0;
      step(2);
      chk("post_rst_serial", 32'(serial_a), 32'd1);
      chk("post_rst_ready", 32'(ready_a), 32'd1);
      chk("post_rst_b_serial", 32'(serial_b), 32'd1);
      chk("post_rst_b_active", 32'(active_b), 32'd0);

      // Single byte 0x53
      n_done = done_cnt;
      send_a(8'h53, 1'b1);
      a = cyc;
      chk("s_ready_low", 32'(ready_a), 32'd0);
      chk("s_lat0", 32'(serial_a), 32'd1);
      step(1);
      chk("s_lat1", 32'(serial_a), 32'd1);
      step(1);
      chk("s_fall", 32'(serial_a), 32'd0);
      chk("s_active", 32'(active_a), 32'd1);
      step(39);
      chk("s_active_pre", 32'(active_a), 32'd1);
      chk("s_done_pre", 32'(done_a), 32'd0);
      step(1);
      chk("s_done_at40", 32'(done_a), 32'd1);
      chk("s_active_drop", 32'(active_a), 32'd0);
      chk("s_done_lat", 32'(cyc - a), 32'd42);
      step(1);
      chk("s_done_pulse", 32'(done_a), 32'd0);
      step(5);
      chk("s_done_cnt", 32'(done_cnt - n_done), 32'd1);

      // Back-to-back 0x45, 0x4E
      n_done = done_cnt;
      n_fall = fall_q.size();
      send_a(8'h45, 1'b1);
      a = cyc;
      step(9);
      send_a(8'h4E, 1'b1);
      chk("b_ready_low", 32'(ready_a), 32'd0);
      step(30);
      chk("b_ready_still", 32'(ready_a), 32'd0);
      step(1);
      chk("b_ready_start2", 32'(ready_a), 32'd1);
      step(50);
      chk("b_done_cnt", 32'(done_cnt - n_done), 32'd2);
      chk("b_fall_cnt", 32'(fall_q.size() - n_fall), 32'd2);
      chk("b_fall_gap", 32'(fall_q[n_fall + 1] - fall_q[n_fall]), 32'd40);
      chk("b_done_gap", 32'(done_q[n_done + 1] - done_q[n_done]), 32'd40);
      chk("b_done_lat", 32'(done_q[n_done] - a), 32'd42);

      // Overflow: same-edge strobe and strobe while held are both dropped
      n_frame = frame_cnt;
      dv_a = 1'b1;
      byte_a = 8'h45;
      sb.push_back(8'h45);
      step(1);
      byte_a = 8'h44;
      step(1);
      dv_a = 1'b0;
      step(8);
      dv_a = 1'b1;
      byte_a = 8'h4E;
      sb.push_back(8'h4E);
      step(1);
      byte_a = 8'h44;
      step(1);
      dv_a = 1'b0;
      byte_a = 8'hFF;
      step(140);
      chk("o_frames", 32'(frame_cnt - n_frame), 32'd2);
      chk("o_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during data bit 3 with a byte held
      send_a(8'h53, 1'b0);
      a = cyc;
      step(7);
      send_a(8'hAA, 1'b0);
      step(10);
      chk("r_bit3_low", 32'(serial_a), 32'd0);
      chk("r_held", 32'(ready_a), 32'd0);
      rst = 1'b1;
      step(1);
      chk("r_serial_high", 32'(serial_a), 32'd1);
      chk("r_active_low", 32'(active_a), 32'd0);
      chk("r_ready_high", 32'(ready_a), 32'd1);
      chk("r_done_low", 32'(done_a), 32'd0);
      rst = 1'b0;
      n_done = done_cnt;
      n_fall = fall_q.size();
      step(80);
      chk("r_no_done", 32'(done_cnt - n_done), 32'd0);
      chk("r_no_frame", 32'(fall_q.size() - n_fall), 32'd0);
      chk("r_idle_line", 32'(serial_a), 32'd1);

      // STOP_BITS=2, byte 0x00
      dv_b = 1'b1;
      byte_b = 8'h00;
      step(1);
      dv_b = 1'b0;
      bad = 0;
      done_off = -1;
      done_hits = 0;
      for (int k = 1; k <= 52; k++) begin
         step(1);
         if (k >= 2 && k - 2 <= 35 && serial_b !== 1'b0) bad++;
         if (k - 2 >= 36 && serial_b !== 1'b1) bad++;
         if (k < 2 && serial_b !== 1'b1) bad++;
         if (done_b === 1'b1) begin
            done_hits++;
            done_off = k - 2;
         end
      end
      chk("sb2_shape", 32'(bad), 32'd0);
      chk("sb2_done_off", 32'(done_off), 32'd44);
      chk("sb2_done_hits", 32'(done_hits), 32'd1);
      chk("sb2_active_end", 32'(active_b), 32'd0);

      chk("sb_left", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
